// File: rtl/audio_pkg.sv
// Shared constants, types and gain helpers for the I2S audio transmitter.
package audio_pkg;

  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  localparam int AUDIO_W    = 16;
  localparam int GAIN_MAX   = 64;
  localparam int GAIN_SHIFT = 6;

  localparam int CNT_W  = $clog2(FRAME_BITS);
  localparam int SLOT_W = $clog2(SLOT_BITS);
  localparam int GAIN_W = 7;

  typedef logic signed [AUDIO_W-1:0] sample_t;

  // Gain moves one step per captured frame, saturating at 0 and GAIN_MAX.
  function automatic logic [GAIN_W-1:0] next_gain(input logic [GAIN_W-1:0] g,
                                                  input logic up);
    if (up) return (g == GAIN_W'(GAIN_MAX)) ? g : g + 1'b1;
    return (g == '0) ? g : g - 1'b1;
  endfunction

  function automatic logic signed [31:0] apply_gain(input logic signed [31:0] s,
                                                    input logic [GAIN_W-1:0] g);
    logic signed [39:0] prod;
    prod = s * $signed({1'b0, g});
    return 32'(prod >>> GAIN_SHIFT);
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// BCLK divider and 64-bit frame counter; flags the BCLK falling edge and frame wrap.
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int BCLK_HALF = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  output logic             bclk,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             fall_evt,
  output logic             frame_evt
);

  localparam int DIV_W = $clog2(BCLK_HALF);

  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;

  // NOTE: the event strobes are combinational so the top registers its outputs on the very edge that drops bclk.
  assign div_wrap  = (div_cnt == DIV_W'(BCLK_HALF - 1));
  assign fall_evt  = en && div_wrap && bclk;
  assign frame_evt = fall_evt && (bit_cnt == CNT_W'(FRAME_BITS - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '1;
    end else if (!en) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '1;
    end else if (div_wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
      if (bclk) bit_cnt <= bit_cnt + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_audio_tx.sv
// Mono sample to Philips-format stereo I2S serialiser with frame strobe.
// Optional soft mute ramp is enabled by defining I2S_SOFT_MUTE_EN.
module i2s_audio_tx
  import audio_pkg::*;
#(
  parameter int BCLK_HALF = 16,
  parameter int DATA_W    = AUDIO_W
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] mout,
  input  logic                     soundon,
  output logic                     sample_stb,
  output logic                     i2s_bclk,
  output logic                     i2s_lrclk,
  output logic                     i2s_sdata
);

  localparam int IDX_W = $clog2(DATA_W);

  logic [CNT_W-1:0]         bit_cnt;
  logic [CNT_W-1:0]         nxt_cnt;
  logic [SLOT_W-1:0]        p;
  logic [IDX_W-1:0]         idx;
  logic                     fall_evt;
  logic                     frame_evt;
  logic                     sdata_nxt;
  logic signed [DATA_W-1:0] hold;
  logic signed [DATA_W-1:0] cap_val;

  i2s_clkgen #(.BCLK_HALF(BCLK_HALF)) u_clkgen (
    .CLK       (CLK),
    .RST       (RST),
    .en        (en),
    .bclk      (i2s_bclk),
    .bit_cnt   (bit_cnt),
    .fall_evt  (fall_evt),
    .frame_evt (frame_evt)
  );

  // Slot position 0 is the one-BCLK delay bit; positions past DATA_W are zero padding.
  always_comb begin
    nxt_cnt   = bit_cnt + 1'b1;
    p         = nxt_cnt[SLOT_W-1:0];
    idx       = IDX_W'(DATA_W - int'(p));
    sdata_nxt = (p != '0 && int'(p) <= DATA_W) ? hold[idx] : 1'b0;
  end

`ifdef I2S_SOFT_MUTE_EN
  logic [GAIN_W-1:0] gain;

  always_comb cap_val = DATA_W'(apply_gain(32'(mout), gain));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            gain <= '0;
    else if (!en)       gain <= '0;
    else if (frame_evt) gain <= next_gain(gain, soundon);
  end
`else
  always_comb cap_val = soundon ? mout : '0;
`endif

  // NOTE: en is a synchronous clear, so it sits below the async RST branch rather than in the sensitivity list.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sample_stb <= 1'b0;
      i2s_lrclk  <= 1'b0;
      i2s_sdata  <= 1'b0;
      hold       <= '0;
    end else if (!en) begin
      sample_stb <= 1'b0;
      i2s_lrclk  <= 1'b0;
      i2s_sdata  <= 1'b0;
      hold       <= '0;
    end else begin
      sample_stb <= frame_evt;
      if (fall_evt) begin
        i2s_lrclk <= nxt_cnt[CNT_W-1];
        i2s_sdata <= sdata_nxt;
      end
      if (frame_evt) hold <= cap_val;
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed + randomized bench: deserialises I2S slots at BCLK rising edges and compares to input samples.
module tb_i2s_audio_tx;
  import audio_pkg::*;

  localparam int BH         = 2;
  localparam int FRAME_CLKS = 128 * BH;

  logic    CLK = 1'b0;
  logic    RST = 1'b1;
  logic    en = 1'b0;
  logic    soundon = 1'b0;
  sample_t mout = '0;
  logic    sample_stb, i2s_bclk, i2s_lrclk, i2s_sdata;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned last_stb = 0;
  bit          contig = 1'b0;

  i2s_audio_tx #(.BCLK_HALF(BH), .DATA_W(AUDIO_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .en         (en),
    .mout       (mout),
    .soundon    (soundon),
    .sample_stb (sample_stb),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrclk  (i2s_lrclk),
    .i2s_sdata  (i2s_sdata)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits for the capture strobe, predicts the word from the inputs seen at capture,
  // then receives 64 bits the way a codec would and checks both slots.
  task automatic frame(input string tag, input bit first, input int chg_at,
                       input sample_t chg_mout, input logic chg_son);
    int          n = 0;
    int          pos = 0;
    int          stbs = 0;
    int          lr_bad = 0;
    int          guard = 0;
    sample_t     e;
    logic [31:0] l = '0;
    logic [31:0] r = '0;
    logic [31:0] w;
    logic        prev;
    do begin
      @(negedge CLK);
      n++;
    end while (!sample_stb && n < FRAME_CLKS + 8);
    e = soundon ? mout : '0;
    if (first) check({tag, " first_lat"}, n, 2 * BH);
    else if (contig) check({tag, " period"}, cyc - last_stb, FRAME_CLKS);
    last_stb = cyc;
    contig   = 1'b1;
    prev     = i2s_bclk;
    while (pos < 64 && guard < FRAME_CLKS + 8) begin
      @(negedge CLK);
      guard++;
      if (sample_stb) stbs++;
      if (i2s_bclk && !prev) begin
        if (pos < 32) l = {l[30:0], i2s_sdata};
        else          r = {r[30:0], i2s_sdata};
        if (i2s_lrclk !== (pos >= 32)) lr_bad++;
        if (pos == chg_at) begin
          mout    = chg_mout;
          soundon = chg_son;
        end
        pos++;
      end
      prev = i2s_bclk;
    end
    w = {1'b0, e, 15'b0};
    check({tag, " bits"}, pos, 64);
    check({tag, " left"}, l, w);
    check({tag, " right"}, r, w);
    check({tag, " stb_width"}, stbs, 0);
    check({tag, " lrclk"}, lr_bad, 0);
  endtask

  initial begin
    int bad;
    int rises;
    int guard;
    logic prev;

    repeat (3) @(negedge CLK);
    check("in_reset", {28'b0, sample_stb, i2s_bclk, i2s_lrclk, i2s_sdata}, 32'd0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("en_low", {28'b0, sample_stb, i2s_bclk, i2s_lrclk, i2s_sdata}, 32'd0);

    mout = 16'h7FC0; soundon = 1'b1; en = 1'b1; contig = 1'b0;
    frame("s1_7fc0", 1'b1, -1, '0, 1'b1);

    mout = 16'h8000;
    frame("s2_8000", 1'b0, 5, 16'h1234, 1'b1);
    frame("s2_1234", 1'b0, -1, '0, 1'b1);

    mout = 16'h5000; soundon = 1'b0;
    frame("s3_mute", 1'b0, -1, '0, 1'b1);
    soundon = 1'b1;
    frame("s3_unmute", 1'b0, -1, '0, 1'b1);

    for (int k = 0; k < 6; k++) begin
      mout    = 16'($urandom);
      soundon = 1'($urandom_range(0, 1));
      frame("rand", 1'b0, $urandom_range(0, 63), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    mout = 16'h7FC0; soundon = 1'b1;
    guard = 0;
    do begin
      @(negedge CLK);
      guard++;
    end while (!sample_stb && guard < FRAME_CLKS + 8);
    rises = 0;
    prev  = i2s_bclk;
    while (rises < 20 && guard < 2 * FRAME_CLKS) begin
      @(negedge CLK);
      guard++;
      if (i2s_bclk && !prev) rises++;
      prev = i2s_bclk;
    end
    check("s4_reach_bit20", rises, 20);
    RST = 1'b1;
    #1;
    check("s4_async_clear", {28'b0, sample_stb, i2s_bclk, i2s_lrclk, i2s_sdata}, 32'd0);
    @(negedge CLK);
    RST = 1'b0; contig = 1'b0;
    frame("s4_restart", 1'b1, -1, '0, 1'b1);

    en  = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge CLK);
      if ({sample_stb, i2s_bclk, i2s_lrclk, i2s_sdata} !== 4'b0) bad++;
    end
    check("s5_hold_low", bad, 0);
    mout = 16'h8000; en = 1'b1; contig = 1'b0;
    frame("s5_first", 1'b1, -1, '0, 1'b1);
    frame("s5_next", 1'b0, -1, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_audio_tx.md
Name: i2s_audio_tx

Overview:
Downstream stage of the 4-channel sound mixer. Takes the mixer's 16-bit signed mono sample and its sound-on flag, and serialises the sample as stereo I2S (Philips format, same sample in both slots) for the board's audio codec. It generates BCLK and LRCLK from the system clock and pulses a frame strobe each time it captures a new sample.

Parameters:
BCLK_HALF, 16, system clocks per BCLK half-period (>=2); 100 MHz/32 gives BCLK 3.125 MHz and fs 48.83 kHz
DATA_W, 16, sample width; must be <= 31

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  asynchronous, active-high reset
en  in  1  run enable; low holds the block in its reset state (synchronous)
mout  in  DATA_W  signed mixed sample from the mixer; sampled only at frame start
soundon  in  1  mixer activity flag; low means mute
sample_stb  out  1  one-CLK pulse when mout is captured
i2s_bclk  out  1  bit clock
i2s_lrclk  out  1  word select; 0 = left slot, 1 = right slot
i2s_sdata  out  1  serial data, MSB first, two's complement

Behaviour:
- Reset / en=0: div_cnt=0, bit_cnt=63, bclk=0, lrclk=0, sdata=0, sample_stb=0, hold=0. Asserting RST mid-frame aborts the frame immediately; there is no partial-word recovery.
- Divider: div_cnt counts 0..BCLK_HALF-1 while en=1. On the CLK where div_cnt=BCLK_HALF-1, div_cnt wraps to 0 and bclk toggles.
- Falling event: a toggle 1->0 of bclk. All output updates happen on this event, registered in the same CLK as the toggle.
  - bit_cnt increments mod 64.
  - lrclk = new bit_cnt[5].
  - Let p = new bit_cnt[4:0]. sdata = hold[DATA_W-p] for p in 1..DATA_W, otherwise 0. This gives a one-BCLK delay after the LRCLK edge, with zero padding to 32 bits per slot.
- Capture: on the falling event where bit_cnt wraps 63->0:
  - hold <= soundon ? mout : 0
  - sample_stb=1 for exactly that CLK.
  - The right slot re-sends the same hold value.
- First frame after reset or after en rises: the first falling event occurs 2*BCLK_HALF CLKs after counting starts. It wraps bit_cnt to 0 and captures.
- Cadence: sample_stb period is exactly 128*BCLK_HALF CLKs.
- mout and soundon are ignored except on the capture CLK. Changes mid-frame never corrupt the word being shifted.
- Both slots carry identical data.
- Boundary values shift out unchanged: 16'h7FC0 and 16'h8000.

Optional Feature:
I2S_SOFT_MUTE_EN
- Defined:
  - A 7-bit gain register, reset 0, steps once per capture: +1 toward 64 when soundon=1, -1 toward 0 when soundon=0.
  - hold <= (mout * gain) >>> 6, arithmetic shift, with mout captured regardless of soundon.
  - A full ramp takes 64 frames. The gain update and the multiply both use the pre-update gain.
- Undefined: hard mute exactly as specified above. No multiplier is present.

Decomposition:
- Package audio_pkg:
  - SLOT_BITS=32, FRAME_BITS=64, AUDIO_W=16
  - GAIN_MAX=64, GAIN_SHIFT=6
  - sample type as signed [AUDIO_W-1:0]
- One sub-module, i2s_clkgen:
  - contents: div_cnt, bclk, bit_cnt, and the fall_evt / frame_evt strobes
  - i2s_audio_tx instantiates it and owns hold, sdata, lrclk and the mute logic.

Test Plan:
1. BCLK_HALF=2, release RST, en=1, mout=16'h7FC0, soundon=1 -> sample_stb at CLK 4 after en. i2s_sdata bits 1..16 of both slots read 0111_1111_1100_0000, bits 17..31 read 0. lrclk period is 256 CLKs.
2. mout=16'h8000, soundon=1 -> each slot's word is 1000_0000_0000_0000. Change mout to 16'h1234 mid-left-slot -> current frame still 8000 in both slots; next frame carries 1234.
3. soundon=0 with mout=16'h5000 (hard-mute build) -> all data bits 0 in the next frame. Restore soundon=1 -> 5000 appears exactly one frame later.
4. Assert RST for 1 CLK at bit_cnt=20 -> all outputs 0 within the same cycle. The restart timing is identical to scenario 1.
5. en low for 300 CLKs, then high -> outputs hold 0 and no sample_stb while low. The first sample_stb arrives 2*BCLK_HALF CLKs after en rises.
6. With I2S_SOFT_MUTE_EN, mout=16'h4000, soundon toggles 0->1 -> captured words ramp 0, 0x0100, 0x0200 … reaching 0x4000 after 65 captures. After soundon=0 they ramp back down to 0.
